// File: rtl/inv_mix_columns.sv
// AES InvMixColumns stage: four independent column multipliers feeding one
// register stage with a valid flag, for use inside a clocked decryption round.

// One 32-bit column times the inverse MixColumns matrix over GF(2^8).
module inv_mix_column (
  input  logic [31:0] col,
  output logic [31:0] result
);

  logic [3:0][7:0] s;
  logic [3:0][7:0] x2;
  logic [3:0][7:0] x4;
  logic [3:0][7:0] x8;
  logic [3:0][7:0] m9;
  logic [3:0][7:0] mb;
  logic [3:0][7:0] md;
  logic [3:0][7:0] me;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // s[0] is the most significant byte of the column.
  always_comb begin
    s  = '0;
    x2 = '0;
    x4 = '0;
    x8 = '0;
    m9 = '0;
    mb = '0;
    md = '0;
    me = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ s[i];
      mb[i] = x8[i] ^ x2[i] ^ s[i];
      md[i] = x8[i] ^ x4[i] ^ s[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  assign result = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};

endmodule

module inv_mix_columns (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] state,
  output logic         out_valid,
  output logic [127:0] result_state
);

  logic [127:0] mixed;

  genvar c;
  generate
    for (c = 0; c < 4; c++) begin : g_col
      inv_mix_column u_col (
        .col    (state[127-32*c -: 32]),
        .result (mixed[127-32*c -: 32])
      );
    end
  endgenerate

  // The data register only loads on valid input, so idle-cycle garbage on
  // state never reaches result_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_state <= '0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result_state <= mixed;
      end
    end
  end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed-vector and round-trip bench for the InvMixColumns pipeline stage.
module tb_inv_mix_columns;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] state;
  logic         out_valid;
  logic [127:0] result_state;

  int checks;
  int failures;

  typedef struct {
    string        name;
    logic [127:0] state;
    logic [127:0] expected;
  } vec_t;

  vec_t vectors [4];

  inv_mix_columns dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .state        (state),
    .out_valid    (out_valid),
    .result_state (result_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns, used to build inputs whose inverse is known.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Drive inputs just after a falling edge; return at the next falling edge,
  // by which time the rising edge in between has registered them.
  task automatic applyStimulus(input logic valid, input logic [127:0] s);
    in_valid = valid;
    state    = s;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic exp_valid,
                             input logic [127:0] exp_state);
    checks++;
    if (out_valid !== exp_valid) begin
      failures++;
      $display("[TB] FAIL %s out_valid: got %0b want %0b", name, out_valid, exp_valid);
    end
    checks++;
    if (result_state !== exp_state) begin
      failures++;
      $display("[TB] FAIL %s result_state: got %h want %h", name, result_state, exp_state);
    end
  endtask

  initial begin
    logic [127:0] orig;
    checks   = 0;
    failures = 0;

    vectors[0] = '{"fips197", 128'h046681e5_e0cb199a_48f8d37a_2806264c,
                              128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    vectors[1] = '{"known_cols", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                                 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vectors[2] = '{"all_ones", {128{1'b1}}, {128{1'b1}}};
    vectors[3] = '{"zero", 128'h0, 128'h0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    state    = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, vectors[i].state);
      checkOutput(vectors[i].name, 1'b1, vectors[i].expected);
    end

    applyStimulus(1'b0, 'x);
    checkOutput("idle_after_zero", 1'b0, 128'h0);

    applyStimulus(1'b1, vectors[0].state);
    checkOutput("hold_setup", 1'b1, vectors[0].expected);
    applyStimulus(1'b0, {4{32'hdeadbeef}});
    checkOutput("idle_hold", 1'b0, vectors[0].expected);

    applyStimulus(1'b1, vectors[0].state);
    checkOutput("stream_first", 1'b1, vectors[0].expected);
    applyStimulus(1'b1, vectors[1].state);
    checkOutput("stream_second", 1'b1, vectors[1].expected);

    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 128'h0);
    @(negedge clk);
    checkOutput("reset_held", 1'b0, 128'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, vectors[0].state);
    checkOutput("after_reset", 1'b1, vectors[0].expected);

    for (int n = 0; n < 1000; n++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, mix_columns(orig));
      checkOutput("round_trip", 1'b1, orig);
    end

    applyStimulus(1'b0, '0);
    checkOutput("final_idle", 1'b0, result_state === 128'h0 ? 128'h1 : result_state);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns.md
Name: inv_mix_columns

Overview:
- AES decryption-round stage applying InvMixColumns to a 128-bit state: each of four 32-bit columns is multiplied in GF(2^8) by the inverse MixColumns matrix.
- Registered (one pipeline stage) with a valid flag, so it drops into the clocked decryption datapath between InvShiftRows/InvSubBytes/AddRoundKey stages.

Parameters:
- none (AES column/state widths are fixed: 4 columns x 4 bytes)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  state is valid this cycle; capture it
- state  input  128  input AES state
- out_valid  output  1  result_state holds a new valid result
- result_state  output  128  InvMixColumns(state), registered

Behaviour:
- Reset: rst_n low asynchronously clears result_state to 128'h0 and out_valid to 0, regardless of clk; held while rst_n is low.
- Byte mapping: byte k = state[127-8k -: 8], k=0..15. Column c (c=0..3) = bytes 4c..4c+3 = state[127-32c -: 32], with s0 in the MSB byte, s3 in the LSB byte. The same mapping applies to result_state.
- Per column, with all products in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B) and + = XOR:
  - r0 = 0E*s0 ^ 0B*s1 ^ 0D*s2 ^ 09*s3
  - r1 = 09*s0 ^ 0E*s1 ^ 0B*s2 ^ 0D*s3
  - r2 = 0D*s0 ^ 09*s1 ^ 0E*s2 ^ 0B*s3
  - r3 = 0B*s0 ^ 0D*s1 ^ 09*s2 ^ 0E*s3
- Multiplication: built from xtime (shift left 1; XOR 0x1B if the shifted-out bit was 1). Definitions:
  - 09 = x8 ^ x1
  - 0B = x8 ^ x2 ^ x1
  - 0D = x8 ^ x4 ^ x1
  - 0E = x8 ^ x4 ^ x2
  - x2 = xtime(s), x4 = xtime(x2), x8 = xtime(x4)
  - Purely combinational within the cycle; no lookup memories.
- Latency: exactly 1 clock. On a rising clk edge with in_valid=1, result_state <= InvMixColumns(state) and out_valid <= 1.
- On an edge with in_valid=0: out_valid <= 0 and result_state holds its previous value.
- Back-to-back: full throughput, one new state accepted every cycle; no backpressure, no ready signal.
- All four columns are processed independently and in parallel; no inter-column dependence.
- Reset asserted mid-operation: the in-flight result is discarded. After rst_n deasserts, the first edge with in_valid=1 produces a valid result one cycle later.
- X on state while in_valid=0 must not affect the outputs.

Test Plan:
- FIPS-197 vector: in_valid=1, state=046681e5_e0cb199a_48f8d37a_2806264c -> one clock later out_valid=1, result_state=d4bf5d30_e0b452ae_b84111f1_1e2798e5.
- Known columns: state=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> result_state=db135345_f20a225c_01010101_c6c6c6c6.
- Zero and idle: state=0 with in_valid=1 -> result 0, out_valid=1. Next cycle in_valid=0 -> out_valid=0 and result_state unchanged.
- Streaming: the two vectors above on consecutive cycles -> results on consecutive cycles in the same order, out_valid held high for 2 cycles.
- Async reset: after a valid result, pull rst_n low between clock edges -> result_state=0 and out_valid=0 immediately, without a clock edge. Release and reapply the FIPS vector -> correct result after 1 clock.
- Round-trip: for 1000 random states, apply a reference MixColumns, feed the output to the DUT -> result_state equals the original state.
